// File: rtl/baud_pkg.sv
// Shared constants and elaboration helpers for the UART baud timing source.
package baud_pkg;

  localparam int unsigned RATE_SEL_W = 2;

  typedef logic [RATE_SEL_W-1:0] rate_sel_t;

  // Phase increment rounded to nearest: round(baud*os*2^width/clock).
  function automatic longint unsigned baud_inc(input int unsigned clock,
                                               input int unsigned baud,
                                               input int unsigned os,
                                               input int unsigned width);
    longint unsigned num;
    num = (64'(baud) * 64'(os)) << width;
    return (num + 64'(clock / 2)) / 64'(clock);
  endfunction

  function automatic bit os_legal(input int unsigned os);
    return (os >= 4) && ((os & (os - 1)) == 0);
  endfunction

endpackage

// File: rtl/baud_nco.sv
// Fractional phase accumulator; os_tick is the registered carry-out.
module baud_nco
  import baud_pkg::*;
#(
  parameter int unsigned         ACC_WIDTH = 24,
  parameter logic [ACC_WIDTH-1:0] INC0     = '0,
  parameter logic [ACC_WIDTH-1:0] INC1     = '0,
  parameter logic [ACC_WIDTH-1:0] INC2     = '0,
  parameter logic [ACC_WIDTH-1:0] INC3     = '0
) (
  input  logic      Clock,
  input  logic      reset,
  input  logic      enable,
  input  logic      clear,
  input  rate_sel_t rate_sel,
  output logic      carry,
  output logic      os_tick
);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] inc;
  logic [ACC_WIDTH:0]   sum;

  always_comb begin
    inc = INC0;
    case (rate_sel)
      2'd1:    inc = INC1;
      2'd2:    inc = INC2;
      2'd3:    inc = INC3;
      default: inc = INC0;
    endcase
  end

  assign sum = {1'b0, acc} + {1'b0, inc};
  // Carry that will appear on os_tick after this edge; lets the parent register strobes aligned with it.
  assign carry = enable & ~clear & sum[ACC_WIDTH];

  always_ff @(posedge Clock) begin
    if (reset || clear) begin
      acc     <= '0;
      os_tick <= 1'b0;
    end else if (enable) begin
      acc     <= sum[ACC_WIDTH-1:0];
      os_tick <= sum[ACC_WIDTH];
    end else begin
      os_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud timing source: NCO oversample strobe, TX bit strobe, re-phasable RX mid-bit strobe, baud_clk.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = 25000000,
  parameter int unsigned BAUD0      = 57600,
  parameter int unsigned BAUD1      = 9600,
  parameter int unsigned BAUD2      = 19200,
  parameter int unsigned BAUD3      = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned ACC_WIDTH  = 24
) (
  input  logic                  Clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [RATE_SEL_W-1:0] rate_sel,
  input  logic                  rx_sync,
  output logic                  os_tick,
  output logic                  tx_tick,
  output logic                  rx_tick,
  output logic                  baud_clk
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);

  localparam logic [ACC_WIDTH-1:0] INC0 = ACC_WIDTH'(baud_inc(CLOCK_RATE, BAUD0, OVERSAMPLE, ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] INC1 = ACC_WIDTH'(baud_inc(CLOCK_RATE, BAUD1, OVERSAMPLE, ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] INC2 = ACC_WIDTH'(baud_inc(CLOCK_RATE, BAUD2, OVERSAMPLE, ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] INC3 = ACC_WIDTH'(baud_inc(CLOCK_RATE, BAUD3, OVERSAMPLE, ACC_WIDTH));

  if (!os_legal(OVERSAMPLE)) begin : g_bad_oversample
    $error("baud_tick_gen: OVERSAMPLE must be a power of two and at least 4");
  end

  rate_sel_t        rate_sel_q;
  logic             rate_chg;
  logic             carry;
  logic [CNT_W-1:0] tx_cnt;
  logic [CNT_W-1:0] rx_cnt;
  logic             rx_armed;

  assign rate_chg = (rate_sel != rate_sel_q);

  baud_nco #(
    .ACC_WIDTH (ACC_WIDTH),
    .INC0      (INC0),
    .INC1      (INC1),
    .INC2      (INC2),
    .INC3      (INC3)
  ) u_nco (
    .Clock    (Clock),
    .reset    (reset),
    .enable   (enable),
    .clear    (rate_chg),
    .rate_sel (rate_sel_q),
    .carry    (carry),
    .os_tick  (os_tick)
  );

  // Strobes are registered from the NCO's pending carry so they land in the same cycle as os_tick.
  always_ff @(posedge Clock) begin
    rate_sel_q <= rate_sel;
    if (reset || rate_chg) begin
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      rx_armed <= 1'b0;
      tx_tick  <= 1'b0;
      rx_tick  <= 1'b0;
      baud_clk <= 1'b0;
    end else if (!enable) begin
      tx_tick <= 1'b0;
      rx_tick <= 1'b0;
    end else begin
      tx_tick <= carry && (tx_cnt == CNT_LAST);
      if (carry) begin
        tx_cnt <= tx_cnt + CNT_W'(1);
        if (tx_cnt == CNT_LAST || tx_cnt == CNT_HALF)
          baud_clk <= ~baud_clk;
      end
      rx_tick <= 1'b0;
      if (rx_sync) begin
        rx_cnt   <= '0;
        rx_armed <= 1'b1;
      end else if (carry && rx_armed) begin
        rx_cnt  <= rx_cnt + CNT_W'(1);
        rx_tick <= (rx_cnt == CNT_HALF);
      end
    end
  end

endmodule
